// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: one valid/ready request channel (command out, completion back).
// The same shape carries each cache's private channel and the shared memory channel.
// The master drives the command and the slave answers with ready/rdata.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, wr, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wr, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between the I-cache and D-cache engines.
// One requester is served at a time. The command is registered onto the memory channel,
// and the requester gets its read data plus a one-cycle ready pulse.
// Every output is a flop. A RESP cycle after each completion lets the requester drop or
// replace its valid.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority on simultaneous
// requests. The default build uses fixed priority, and the D-cache wins ties.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  cache_mem_arbiter_if.slave         i_req,
  cache_mem_arbiter_if.slave         d_req,
  cache_mem_arbiter_if.master        mem,
  output logic                       busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2,
    StResp   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  // Grant history: 1 when the D-cache was the last requester served.
  logic              last_d_q, last_d_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              pick_d;

  // Winner selection, used only when at least one request is valid in IDLE
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, pick the requester not served last. A lone requester always wins.
    pick_d = d_req.valid & (~i_req.valid | ~last_d_q);
`else
    pick_d = d_req.valid;
`endif
  end

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_valid_d = mem_valid_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (i_req.valid || d_req.valid) begin
          mem_valid_d = 1'b1;
          if (pick_d) begin
            mem_wr_d    = d_req.wr;
            mem_addr_d  = d_req.addr;
            mem_wdata_d = d_req.wdata;
            state_d     = StServeD;
          end else begin
            mem_wr_d    = i_req.wr;
            mem_addr_d  = i_req.addr;
            mem_wdata_d = i_req.wdata;
            state_d     = StServeI;
          end
        end
      end
      StServeI: begin
        // Completion is driven by memory alone. A dropped i_req.valid does not abort.
        if (mem.ready) begin
          mem_valid_d = 1'b0;
          i_rdata_d   = mem_wr_q ? '0 : mem.rdata;
          i_ready_d   = 1'b1;
          last_d_d    = 1'b0;
          state_d     = StResp;
        end
      end
      StServeD: begin
        if (mem.ready) begin
          mem_valid_d = 1'b0;
          d_rdata_d   = mem_wr_q ? '0 : mem.rdata;
          d_ready_d   = 1'b1;
          last_d_d    = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        // Recovery cycle: requests are not sampled here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem.valid   = mem_valid_q;
  assign mem.wr      = mem_wr_q;
  assign mem.addr    = mem_addr_q;
  assign mem.wdata   = mem_wdata_q;
  assign i_req.ready = i_ready_q;
  assign i_req.rdata = i_rdata_q;
  assign d_req.ready = d_ready_q;
  assign d_req.rdata = d_rdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbiter and a simple memory.
module tb_cache_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_if ();
  cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();
  cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_req (i_if),
    .d_req (d_if),
    .mem   (m_if),
    .busy  (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: raises ready mem_lat cycles after it first sees valid.
  logic          auto_rdy = 1'b0;
  logic          spur     = 1'b0;
  logic [DW-1:0] mem_rdata_r = '0;
  int            mem_lat = 1;
  int            mem_cnt = 0;
  logic          ovr_en = 1'b0;
  logic [AW-1:0] ovr_addr = '0;
  logic [DW-1:0] ovr_data = '0;
  logic [DW-1:0] mem_array [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  assign m_if.ready = auto_rdy | spur;
  assign m_if.rdata = mem_rdata_r;

  function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst || !m_if.valid || auto_rdy) begin
      auto_rdy = 1'b0;
      mem_cnt  = 0;
    end else if (mem_cnt >= mem_lat) begin
      auto_rdy = 1'b1;
      if (m_if.wr) begin
        mem_array[m_if.addr] = m_if.wdata;
        mem_rdata_r = 32'hBAD0_BAD0;
      end else if (ovr_en && m_if.addr == ovr_addr) begin
        mem_rdata_r = ovr_data;
      end else if (mem_array.exists(m_if.addr)) begin
        mem_rdata_r = mem_array[m_if.addr];
      end else begin
        mem_rdata_r = hash(m_if.addr);
      end
    end else begin
      mem_cnt++;
    end
  end

  task automatic drv_i(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    i_if.valid = v; i_if.wr = w; i_if.addr = a; i_if.wdata = wd;
  endtask

  task automatic drv_d(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    d_if.valid = v; d_if.wr = w; d_if.addr = a; d_if.wdata = wd;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    drv_i(1'b0, 1'b0, '0, '0);
    drv_d(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drv_i(1'b1, 1'b0, 32'h10, '0);
    drv_d(1'b1, 1'b1, 32'h20, 32'h55);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({m_if.valid, busy, i_if.ready, d_if.ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid/busy/irdy/drdy=%b%b%b%b expected 0000",
               m_if.valid, busy, i_if.ready, d_if.ready);
    end
    n_tests++;
    if ({m_if.wr, m_if.addr, m_if.wdata, i_if.rdata, d_if.rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got wr=%b addr=%0h wdata=%0h irdata=%0h drdata=%0h expected 0",
               m_if.wr, m_if.addr, m_if.wdata, i_if.rdata, d_if.rdata);
    end
    drv_i(1'b0, 1'b0, '0, '0);
    drv_d(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({m_if.valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got valid/busy=%b%b expected 00", m_if.valid, busy);
    end
  endtask

  task automatic test_i_read();
    int   k;
    logic got;
    ovr_en = 1'b1; ovr_addr = 32'h40; ovr_data = 32'h1234_5678; mem_lat = 3;
    @(negedge clk);
    drv_i(1'b1, 1'b0, 32'h40, '0);
    @(negedge clk);
    n_tests++;
    if ({m_if.valid, m_if.wr, m_if.addr, busy} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL i_read_issue: got v=%b wr=%b addr=%0h busy=%b expected 1 0 40 1",
               m_if.valid, m_if.wr, m_if.addr, busy);
    end
    got = 1'b0; k = 0;
    while (!got && k < 12) begin
      @(negedge clk);
      k++;
      if (i_if.ready) got = 1'b1;
    end
    n_tests++;
    if (!got || k != 4) begin
      n_fail++;
      $display("FAIL i_read_latency: got ready=%b after %0d cycles expected 1 after 4", got, k);
    end
    n_tests++;
    if (i_if.rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL i_read_rdata: got %0h expected 12345678", i_if.rdata);
    end
    n_tests++;
    if ({m_if.valid, d_if.ready, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL i_read_resp: got valid/drdy/busy=%b%b%b expected 001",
               m_if.valid, d_if.ready, busy);
    end
    drv_i(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({i_if.ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL i_read_pulse: got irdy/busy=%b%b expected 00", i_if.ready, busy);
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_d_write();
    int   k;
    logic got;
    mem_lat = 2;
    @(negedge clk);
    drv_d(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF);
    got = 1'b0; k = 0;
    while (!got && k < 12) begin
      @(negedge clk);
      k++;
      if (d_if.ready) begin
        got = 1'b1;
      end else begin
        n_tests++;
        if ({m_if.valid, m_if.wr, m_if.addr, m_if.wdata} !== {1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF})
        begin
          n_fail++;
          $display("FAIL d_write_hold: got v=%b wr=%b addr=%0h wdata=%0h expected 1 1 80 deadbeef",
                   m_if.valid, m_if.wr, m_if.addr, m_if.wdata);
        end
      end
    end
    n_tests++;
    if (!got || d_if.rdata !== '0 || i_if.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL d_write_done: got ready=%b rdata=%0h irdy=%b expected 1 0 0",
               got, d_if.rdata, i_if.ready);
    end
    drv_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_tests++;
    if (d_if.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL d_write_pulse: got drdy=%b expected 0", d_if.ready);
    end
  endtask

  task automatic test_arbitration();
    int            order [4];
    int            exp_order [4];
    int            n_done;
    int            ci;
    int            cd;
    logic [AW-1:0] ai;
    logic [AW-1:0] ad;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 0, 0};
`endif
    order = '{-1, -1, -1, -1};
    pulse_reset();
    mem_lat = 2;
    ai = 32'h100; ad = 32'h200;
    drv_i(1'b1, 1'b0, ai, '0);
    drv_d(1'b1, 1'b0, ad, '0);
    n_done = 0; ci = 0; cd = 0;
    for (int k = 0; k < 80 && n_done < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (i_if.ready && d_if.ready) begin
        n_fail++;
        $display("FAIL arb_both_ready: got 1 1 expected at most one");
      end
      if (d_if.ready) begin
        order[n_done] = 1; n_done++; cd++;
        n_tests++;
        if (d_if.rdata !== hash(ad)) begin
          n_fail++;
          $display("FAIL arb_d_rdata: got %0h expected %0h", d_if.rdata, hash(ad));
        end
        ad = ad + 4;
        drv_d(cd < 2, 1'b0, ad, '0);
      end else if (i_if.ready) begin
        order[n_done] = 0; n_done++; ci++;
        n_tests++;
        if (i_if.rdata !== hash(ai)) begin
          n_fail++;
          $display("FAIL arb_i_rdata: got %0h expected %0h", i_if.rdata, hash(ai));
        end
        ai = ai + 4;
        drv_i(ci < 2, 1'b0, ai, '0);
      end
    end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (order[j] != exp_order[j]) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: got %0d expected %0d (1=D 0=I)", j, order[j], exp_order[j]);
      end
    end
    drv_i(1'b0, 1'b0, '0, '0);
    drv_d(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic any_pulse;
    logic got;
    mem_lat = 5;
    @(negedge clk);
    drv_i(1'b1, 1'b0, 32'h300, '0);
    @(negedge clk);
    n_tests++;
    if (m_if.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_issue: got valid=%b expected 1", m_if.valid);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({m_if.valid, busy, i_if.ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got valid/busy/irdy=%b%b%b expected 000",
               m_if.valid, busy, i_if.ready);
    end
    rst = 1'b0;
    drv_i(1'b0, 1'b0, '0, '0);
    any_pulse = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_pulse = any_pulse | i_if.ready | d_if.ready | m_if.valid;
    end
    n_tests++;
    if (any_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got activity=%b expected 0", any_pulse);
    end
    mem_lat = 2;
    drv_i(1'b1, 1'b0, 32'h304, '0);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (i_if.ready) got = 1'b1;
    end
    n_tests++;
    if (!got || i_if.rdata !== hash(32'h304)) begin
      n_fail++;
      $display("FAIL rst_mid_recover: got ready=%b rdata=%0h expected 1 %0h",
               got, i_if.rdata, hash(32'h304));
    end
    drv_i(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_drop();
    logic got;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    n_tests++;
    if ({i_if.ready, d_if.ready, m_if.valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL spur_ready: got irdy/drdy/valid=%b%b%b expected 000",
               i_if.ready, d_if.ready, m_if.valid);
    end
    @(negedge clk);
    n_tests++;
    if ({i_if.ready, d_if.ready, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL spur_after: got irdy/drdy/busy=%b%b%b expected 000",
               i_if.ready, d_if.ready, busy);
    end
    mem_lat = 4;
    drv_i(1'b1, 1'b0, 32'h400, '0);
    @(negedge clk);
    drv_i(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_tests++;
    if (m_if.valid !== 1'b1 || m_if.addr !== 32'h400) begin
      n_fail++;
      $display("FAIL drop_hold: got valid=%b addr=%0h expected 1 400", m_if.valid, m_if.addr);
    end
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (i_if.ready) got = 1'b1;
    end
    n_tests++;
    if (!got || i_if.rdata !== hash(32'h400)) begin
      n_fail++;
      $display("FAIL drop_complete: got ready=%b rdata=%0h expected 1 %0h",
               got, i_if.rdata, hash(32'h400));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   t_rise [2];
    int   n_rise;
    int   n_rdy;
    logic prev_v;
    mem_lat = 1;
    t_rise = '{0, 0};
    @(negedge clk);
    drv_i(1'b1, 1'b0, 32'h500, '0);
    n_rise = 0; n_rdy = 0; prev_v = 1'b0;
    for (int k = 0; k < 30 && n_rdy < 2; k++) begin
      @(negedge clk);
      if (m_if.valid && !prev_v && n_rise < 2) begin
        t_rise[n_rise] = k;
        n_rise++;
      end
      prev_v = m_if.valid;
      if (i_if.ready) begin
        n_rdy++;
        drv_i(n_rdy < 2, 1'b0, 32'h504, '0);
      end
    end
    n_tests++;
    if (n_rise != 2 || t_rise[1] - t_rise[0] != 4) begin
      n_fail++;
      $display("FAIL b2b_turnaround: got %0d rises spaced %0d expected 2 spaced 4",
               n_rise, t_rise[1] - t_rise[0]);
    end
    n_tests++;
    if (i_if.rdata !== hash(32'h504)) begin
      n_fail++;
      $display("FAIL b2b_rdata: got %0h expected %0h", i_if.rdata, hash(32'h504));
    end
    drv_i(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
  endtask

  // Transaction-level model: a request present while the arbiter is free is granted on the
  // next edge. Its completion follows the memory handshake. The arbiter frees up two edges
  // after that handshake.
  task automatic test_random(input int cycles);
    logic          pi, pd, wi, wdr, in_txn, grant_now, hs_prev, arb_free, cur_d, last_d_m;
    logic          cur_wr;
    logic [AW-1:0] ai, ad, cur_addr;
    logic [DW-1:0] di, dd, cur_wdata, exp_rd;
    int            free_from;
    ref_mem.delete();
    pulse_reset();
    pi = 0; pd = 0; wi = 0; wdr = 0; ai = '0; ad = '0; di = '0; dd = '0;
    in_txn = 0; grant_now = 0; hs_prev = 0; arb_free = 1; free_from = 0; last_d_m = 0;
    cur_d = 0; cur_wr = 0; cur_addr = '0; cur_wdata = '0;
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk);
      if (hs_prev) begin
        exp_rd = cur_wr ? '0 : (ref_mem.exists(cur_addr) ? ref_mem[cur_addr] : hash(cur_addr));
        if (cur_wr) ref_mem[cur_addr] = cur_wdata;
        n_tests++;
        if ({i_if.ready, d_if.ready} !== {~cur_d, cur_d}) begin
          n_fail++;
          $display("FAIL rnd_ready @%0d: got irdy/drdy=%b%b expected %b%b",
                   n, i_if.ready, d_if.ready, ~cur_d, cur_d);
        end
        n_tests++;
        if ((cur_d ? d_if.rdata : i_if.rdata) !== exp_rd) begin
          n_fail++;
          $display("FAIL rnd_rdata @%0d: got %0h expected %0h", n,
                   cur_d ? d_if.rdata : i_if.rdata, exp_rd);
        end
        in_txn = 0; arb_free = 1; free_from = n + 1; last_d_m = cur_d;
        if (cur_d) begin pd = 0; d_if.valid = 1'b0; end
        else       begin pi = 0; i_if.valid = 1'b0; end
      end else begin
        n_tests++;
        if ({i_if.ready, d_if.ready} !== 2'b00) begin
          n_fail++;
          $display("FAIL rnd_noready @%0d: got irdy/drdy=%b%b expected 00",
                   n, i_if.ready, d_if.ready);
        end
      end
      if (grant_now) begin
        in_txn = 1; grant_now = 0;
      end
      n_tests++;
      if (m_if.valid !== in_txn ||
          (in_txn && {m_if.wr, m_if.addr, m_if.wdata} !== {cur_wr, cur_addr, cur_wdata})) begin
        n_fail++;
        $display("FAIL rnd_mem @%0d: got v=%b wr=%b addr=%0h wdata=%0h expected %b %b %0h %0h",
                 n, m_if.valid, m_if.wr, m_if.addr, m_if.wdata, in_txn, cur_wr, cur_addr,
                 cur_wdata);
      end
      hs_prev = m_if.valid && m_if.ready;
      if (!pi && $urandom_range(0, 2) == 0) begin
        pi = 1; wi = 1'($urandom_range(0, 1)); ai = 32'($urandom_range(0, 15)) << 2;
        di = $urandom;
        drv_i(1'b1, wi, ai, di);
      end
      if (!pd && $urandom_range(0, 2) == 0) begin
        pd = 1; wdr = 1'($urandom_range(0, 1)); ad = 32'($urandom_range(0, 15)) << 2;
        dd = $urandom;
        drv_d(1'b1, wdr, ad, dd);
      end
      if (arb_free && n >= free_from && (pi || pd)) begin
        if (pi && pd) begin
`ifdef ARB_ROUND_ROBIN_EN
          cur_d = !last_d_m;
`else
          cur_d = 1'b1;
`endif
        end else begin
          cur_d = pd;
        end
        cur_wr    = cur_d ? wdr : wi;
        cur_addr  = cur_d ? ad : ai;
        cur_wdata = cur_d ? dd : di;
        grant_now = 1; arb_free = 0;
        mem_lat   = $urandom_range(1, 4);
      end
    end
    drv_i(1'b0, 1'b0, '0, '0);
    drv_d(1'b0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    drv_i(1'b0, 1'b0, '0, '0);
    drv_d(1'b0, 1'b0, '0, '0);
    test_reset();
    test_i_read();
    test_d_write();
    test_arbitration();
    test_reset_mid();
    test_spurious_drop();
    test_back_to_back();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed",
             n_tests, n_fail);
    $fatal(1);
  end

endmodule
